fp_div_arb: RTL and testbench
=============================

FP_DIV_ARB -- requirements
Module: FP_Div_Arb

Interface
REQ-001 Parameter LATENCY, default 25, the number of WAIT cycles granted to the shared divider; legal range 2..63.
REQ-002 in_Clk  input  1  Sole clock; all state updates on rising edge.
REQ-003 in_Rst_N  input  1  Reset, asynchronous and active-low.
REQ-004 in_req0, in_req1  input  1 each  Division request from requester 0 / 1 (level).
REQ-005 in_op_a0, in_op_b0, in_op_a1, in_op_b1  input  32 each  Dividend / divisor (IEEE-754 single) per requester.
REQ-006 out_gnt0, out_gnt1  output  1 each  One-cycle grant; operands of that requester have been latched.
REQ-007 out_done0, out_done1  output  1 each  One-cycle completion strobe; out_result is valid for that requester.
REQ-008 out_result  output  32  Registered quotient of the most recently completed operation.
REQ-009 out_busy  output  1  High whenever the FSM is not in IDLE.
REQ-010 out_div_start  output  1  One-cycle start pulse to the shared divider.
REQ-011 out_div_a, out_div_b  output  32 each  Latched operands driven to the divider; stable from ISSUE through DONE.
REQ-012 in_div_stall  input  1  Divider-busy indication from the divider controller.
REQ-013 in_div_result  input  32  Divider quotient.

Function
REQ-014 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE. All outputs except out_result SHALL be Moore-decoded from state plus the owner register.
REQ-015 In IDLE with exactly one of in_req0 or in_req1 high, the block SHALL select that requester regardless of the priority pointer.
REQ-016 In IDLE with both requests high, the block SHALL select the requester named by the 1-bit priority pointer.
REQ-017 On leaving IDLE, the block SHALL latch the selected operands into out_div_a/out_div_b, record the owner ID, and go to ISSUE.
REQ-018 In ISSUE (exactly one cycle), the block SHALL assert out_gnt[owner]=1 and out_div_start=1, load the 6-bit counter with LATENCY, and go to WAIT.
REQ-019 WAIT SHALL decrement the counter each cycle and saturate at 0.
REQ-020 WAIT SHALL exit to DONE in the cycle where the counter is ≤1 and in_div_stall=0.
REQ-021 If in_div_stall is still high when the counter reaches 0, the block SHALL remain in WAIT until in_div_stall falls; there is no timeout.
REQ-022 On the WAIT->DONE edge, the block SHALL capture in_div_result into out_result.
REQ-023 out_result SHALL hold its value until the next WAIT->DONE edge.
REQ-024 In DONE (exactly one cycle), the block SHALL assert out_done[owner]=1.
REQ-025 In DONE, the priority pointer SHALL be set to the non-owner, and the FSM SHALL return to IDLE.
REQ-026 Latency: request sampled in IDLE at cycle 0 -> gnt/start at cycle 1 -> done at cycle LATENCY+2 (27 at default), with in_div_stall low by then.
REQ-027 Requests SHALL be ignored outside IDLE. A requester may drop req after its gnt.
REQ-028 A req still high in DONE SHALL be treated as a new request in the following IDLE cycle, giving one IDLE bubble between back-to-back operations.
REQ-029 Changes to in_op_* after gnt SHALL NOT affect out_div_a/out_div_b.
REQ-030 out_gnt0/out_gnt1 SHALL never be high together; likewise out_done0/out_done1.
REQ-031 The block performs no arithmetic on operands or result; special values (0, Inf, NaN) SHALL pass through unmodified.

Reset
REQ-032 While in_Rst_N=0, the block SHALL hold state=IDLE, counter=0, priority pointer=0 (requester 0 favored), owner=0, out_result=0x00000000, and out_div_a/out_div_b=0.
REQ-033 While in_Rst_N=0, all strobes (gnt, done, out_div_start) and out_busy SHALL be 0.
REQ-034 Reset asserted mid-operation (any state) SHALL abort the operation: no done strobe, result not updated, and the FSM resumes in IDLE on release.
REQ-035 Release of reset SHALL be taken synchronously to in_Clk, so the first request is sampled on the first rising edge after deassertion.

Verification
REQ-036 Single request: in_req0=1, a=0x40400000, b=0x3F800000, divider stub returns 0x40400000, stall low -> gnt0 at cycle 1, out_div_start at cycle 1, done0 at cycle 27, out_result=0x40400000.
REQ-037 Simultaneous requests after reset: both req high -> requester 0 served first, done0 at cycle 27, gnt1 at cycle 29, done1 at cycle 55, pointer ends at 0.
REQ-038 Fairness: both req held high for 4 operations -> grant order 0,1,0,1, and gnt0/gnt1 never coincide.
REQ-039 Stall extension: in_div_stall held high for 5 cycles past counter expiry -> done delayed to cycle 32, and out_result captured only then.
REQ-040 Reset mid-WAIT: assert in_Rst_N=0 at cycle 10 of an operation -> outputs cleared immediately, no done strobe; a new req1 after release -> gnt1 one cycle later.
REQ-041 Operand stability: change in_op_a0 to 0xFFFFFFFF at cycle 2 -> out_div_a stays 0x40400000 until DONE.

Source files
------------

// File: rtl/fp_div_arb.sv
// -----------------------------------------------------------------------------
// fp_div_arb
//
// Two-requester arbiter in front of one shared floating-point divider.
// A requester raises its req level with its operands on op_a/op_b. The
// arbiter picks one requester, latches its operands, pulses a grant and a
// divider start, waits a fixed number of cycles (extended while the divider
// reports stall), captures the quotient and pulses a done strobe back to the
// owner. When both requesters ask at once, a one-bit priority pointer decides,
// and it flips to the other requester after every completed operation.
//
// No arithmetic is performed here: operands and the quotient pass through
// bit-exact, so zeros, infinities and NaNs reach their destination untouched.
//
// Parameters
//   LATENCY        number of WAIT cycles granted to the divider (2..63)
//
// Ports
//   in_Clk         clock, all state changes on the rising edge
//   in_Rst_N       asynchronous active-low reset
//   in_req0/1      request level from requester 0 / 1
//   in_op_a0/b0    dividend / divisor of requester 0
//   in_op_a1/b1    dividend / divisor of requester 1
//   out_gnt0/1     one-cycle grant, operands of that requester are latched
//   out_done0/1    one-cycle completion strobe, out_result is valid
//   out_result     quotient of the most recently completed operation
//   out_busy       high whenever the arbiter is not idle
//   out_div_start  one-cycle start pulse to the divider
//   out_div_a/b    latched operands presented to the divider
//   in_div_stall   divider still busy
//   in_div_result  divider quotient
// -----------------------------------------------------------------------------
module fp_div_arb #(
  parameter int LATENCY = 25
) (
  input  logic        in_Clk,
  input  logic        in_Rst_N,
  input  logic        in_req0,
  input  logic        in_req1,
  input  logic [31:0] in_op_a0,
  input  logic [31:0] in_op_b0,
  input  logic [31:0] in_op_a1,
  input  logic [31:0] in_op_b1,
  output logic        out_gnt0,
  output logic        out_gnt1,
  output logic        out_done0,
  output logic        out_done1,
  output logic [31:0] out_result,
  output logic        out_busy,
  output logic        out_div_start,
  output logic [31:0] out_div_a,
  output logic [31:0] out_div_b,
  input  logic        in_div_stall,
  input  logic [31:0] in_div_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [5:0] LOAD_VALUE = LATENCY[5:0];

  state_t      state;
  state_t      state_nxt;
  logic        owner;
  logic        prio;
  logic [5:0]  count;
  logic        any_req;
  logic        sel;
  logic        wait_exit;

  assign any_req = in_req0 | in_req1;

  // A lone request wins regardless of the pointer; only a tie consults it.
  assign sel = (in_req0 & in_req1) ? prio : in_req1;

  // The divider gets at least LATENCY cycles; exiting at count<=1 rather than
  // 0 lands done exactly LATENCY+2 cycles after the request was sampled.
  assign wait_exit = (state == WAIT) && (count <= 6'd1) && !in_div_stall;

  // State register. Reset drops straight back to IDLE from any state, which
  // abandons whatever operation was in flight.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus Moore outputs. Every strobe depends only on the
  // current state and the registered owner, so nothing here is combinationally
  // reachable from the request inputs.
  always_comb begin
    state_nxt     = state;
    out_gnt0      = 1'b0;
    out_gnt1      = 1'b0;
    out_done0     = 1'b0;
    out_done1     = 1'b0;
    out_div_start = 1'b0;
    out_busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        out_div_start = 1'b1;
        out_gnt0      = ~owner;
        out_gnt1      = owner;
        state_nxt     = WAIT;
      end
      WAIT: begin
        if (wait_exit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_done0 = ~owner;
        out_done1 = owner;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers: owner, priority pointer, wait counter, latched
  // operands and the captured quotient. Operands are only written when
  // leaving IDLE, so a requester is free to change its inputs after grant.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      owner      <= 1'b0;
      prio       <= 1'b0;
      count      <= 6'd0;
      out_div_a  <= 32'd0;
      out_div_b  <= 32'd0;
      out_result <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= sel;
            out_div_a <= sel ? in_op_a1 : in_op_a0;
            out_div_b <= sel ? in_op_b1 : in_op_b0;
          end
        end
        ISSUE: begin
          count <= LOAD_VALUE;
        end
        WAIT: begin
          if (count != 6'd0) begin
            count <= count - 6'd1;
          end
          if (wait_exit) begin
            out_result <= in_div_result;
          end
        end
        DONE: begin
          prio <= ~owner;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_arb.sv
// -----------------------------------------------------------------------------
// tb_fp_div_arb
//
// Directed bench for fp_div_arb. The stimulus process issues requests and
// pushes the grant/done events it expects (owner, cycle, operands, result)
// into a scoreboard queue; an independent monitor pops an entry whenever the
// DUT shows a grant or done strobe and compares. A small divider stub maps a
// handful of hand-picked operand pairs to their IEEE-754 quotients.
// -----------------------------------------------------------------------------
module tb_fp_div_arb;

  localparam int LAT = 25;

  typedef struct {
    bit          is_done;
    bit          id;
    int          cyc;
    logic [31:0] res;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req0;
  logic        req1;
  logic [31:0] op_a0;
  logic [31:0] op_b0;
  logic [31:0] op_a1;
  logic [31:0] op_b1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [31:0] result;
  logic        busy;
  logic        div_start;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_stall;
  logic [31:0] div_result;

  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  fp_div_arb #(.LATENCY(LAT)) dut (
    .in_Clk        (clk),
    .in_Rst_N      (rst_n),
    .in_req0       (req0),
    .in_req1       (req1),
    .in_op_a0      (op_a0),
    .in_op_b0      (op_b0),
    .in_op_a1      (op_a1),
    .in_op_b1      (op_b1),
    .out_gnt0      (gnt0),
    .out_gnt1      (gnt1),
    .out_done0     (done0),
    .out_done1     (done1),
    .out_result    (result),
    .out_busy      (busy),
    .out_div_start (div_start),
    .out_div_a     (div_a),
    .out_div_b     (div_b),
    .in_div_stall  (div_stall),
    .in_div_result (div_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Divider stub: known quotients for the vectors used below.
  always_comb begin
    div_result = 32'hDEADBEEF;
    case ({div_a, div_b})
      {32'h40400000, 32'h3F800000}: div_result = 32'h40400000; // 3 / 1 = 3
      {32'h41200000, 32'h40A00000}: div_result = 32'h40000000; // 10 / 5 = 2
      {32'h3F800000, 32'h00000000}: div_result = 32'h7F800000; // 1 / 0 = +Inf
      {32'h7FC00000, 32'h3F800000}: div_result = 32'h7FC00000; // NaN / 1 = NaN
      default: div_result = 32'hDEADBEEF;
    endcase
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d",
               name, actual, expected, cyc);
    end
  endtask

  task automatic push_exp(input bit is_done, input bit id, input int at,
                          input logic [31:0] res, input logic [31:0] a,
                          input logic [31:0] b);
    exp_t e;
    e.is_done = is_done;
    e.id      = id;
    e.cyc     = at;
    e.res     = res;
    e.a       = a;
    e.b       = b;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input bit id, input logic [31:0] a,
                                input logic [31:0] b);
    if (id) begin
      op_a1 = a;
      op_b1 = b;
      req1  = 1'b1;
    end else begin
      op_a0 = a;
      op_b0 = b;
      req0  = 1'b1;
    end
  endtask

  // Monitor: every grant/done strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (gnt0 | gnt1 | done0 | done1)) begin
      checks++;
      if ((gnt0 & gnt1) | (done0 & done1) | ((gnt0 | gnt1) & (done0 | done1))) begin
        errors++;
        $display("[TB] FAIL strobe_exclusive: gnt=%b%b done=%b%b at cycle %0d",
                 gnt1, gnt0, done1, done0, cyc);
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe: gnt=%b%b done=%b%b at cycle %0d, none expected",
                 gnt1, gnt0, done1, done0, cyc);
      end else begin
        e = sb.pop_front();
        check_output("event_kind", {31'd0, done0 | done1}, {31'd0, e.is_done});
        check_output("event_owner", {31'd0, (done0 | done1) ? done1 : gnt1}, {31'd0, e.id});
        check_output("event_cycle", cyc, e.cyc);
        check_output("event_div_a", div_a, e.a);
        check_output("event_div_b", div_b, e.b);
        if (e.is_done) begin
          check_output("done_result", result, e.res);
        end else begin
          check_output("gnt_div_start", {31'd0, div_start}, 32'd1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req0      = 1'b0;
    req1      = 1'b0;
    op_a0     = 32'd0;
    op_b0     = 32'd0;
    op_a1     = 32'd0;
    op_b1     = 32'd0;
    div_stall = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    check_output("rst_done", {30'd0, done1, done0}, 32'd0);
    check_output("rst_start", {31'd0, div_start}, 32'd0);
    check_output("rst_result", result, 32'd0);
    check_output("rst_div_a", div_a, 32'd0);
    check_output("rst_div_b", div_b, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, operand change after grant must not leak through
    $display("[TB] single request 3.0 / 1.0");
    c = cyc;
    apply_stimulus(1'b0, 32'h40400000, 32'h3F800000);
    push_exp(1'b0, 1'b0, c + 1, 32'h0, 32'h40400000, 32'h3F800000);
    push_exp(1'b1, 1'b0, c + LAT + 2, 32'h40400000, 32'h40400000, 32'h3F800000);
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    op_a0 = 32'hFFFFFFFF;
    repeat (8) @(negedge clk);
    check_output("busy_in_wait", {31'd0, busy}, 32'd1);
    check_output("div_a_stable", div_a, 32'h40400000);
    repeat (22) @(negedge clk);
    check_output("idle_after_single", {31'd0, busy}, 32'd0);
    check_output("result_held", result, 32'h40400000);

    // Lone request 0 while the pointer favours requester 1
    $display("[TB] lone request against pointer, 10.0 / 5.0");
    c = cyc;
    apply_stimulus(1'b0, 32'h41200000, 32'h40A00000);
    push_exp(1'b0, 1'b0, c + 1, 32'h0, 32'h41200000, 32'h40A00000);
    push_exp(1'b1, 1'b0, c + LAT + 2, 32'h40000000, 32'h41200000, 32'h40A00000);
    @(negedge clk);
    req0 = 1'b0;
    repeat (30) @(negedge clk);

    // Reset in the middle of WAIT, then a fresh request from requester 1
    $display("[TB] reset mid-wait");
    c = cyc;
    apply_stimulus(1'b0, 32'h3F800000, 32'h00000000);
    push_exp(1'b0, 1'b0, c + 1, 32'h0, 32'h3F800000, 32'h00000000);
    @(negedge clk);
    req0 = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("midrst_busy", {31'd0, busy}, 32'd0);
    check_output("midrst_strobes", {27'd0, gnt1, gnt0, done1, done0, div_start}, 32'd0);
    check_output("midrst_result", result, 32'd0);
    check_output("midrst_div_a", div_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    c = cyc;
    apply_stimulus(1'b1, 32'h7FC00000, 32'h3F800000);
    push_exp(1'b0, 1'b1, c + 1, 32'h0, 32'h7FC00000, 32'h3F800000);
    push_exp(1'b1, 1'b1, c + LAT + 2, 32'h7FC00000, 32'h7FC00000, 32'h3F800000);
    @(negedge clk);
    req1 = 1'b0;
    repeat (30) @(negedge clk);
    check_output("nan_passthrough", result, 32'h7FC00000);

    // Divider stall keeps the arbiter in WAIT five cycles past expiry
    $display("[TB] stall extension");
    div_stall = 1'b1;
    c = cyc;
    apply_stimulus(1'b0, 32'h40400000, 32'h3F800000);
    push_exp(1'b0, 1'b0, c + 1, 32'h0, 32'h40400000, 32'h3F800000);
    push_exp(1'b1, 1'b0, c + LAT + 7, 32'h40400000, 32'h40400000, 32'h3F800000);
    @(negedge clk);
    req0 = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    check_output("stall_result_old", result, 32'h7FC00000);
    check_output("stall_busy", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    check_output("stall_result_late", result, 32'h7FC00000);
    div_stall = 1'b0;
    repeat (3) @(negedge clk);
    check_output("stall_result_new", result, 32'h40400000);
    repeat (2) @(negedge clk);

    // Simultaneous requests held for four operations after a fresh reset
    $display("[TB] simultaneous requests / fairness");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    c = cyc;
    apply_stimulus(1'b0, 32'h41200000, 32'h40A00000);
    apply_stimulus(1'b1, 32'h3F800000, 32'h00000000);
    for (int k = 0; k < 4; k++) begin
      bit id;
      id = k[0];
      push_exp(1'b0, id, c + 1 + 28 * k, 32'h0,
               id ? 32'h3F800000 : 32'h41200000,
               id ? 32'h00000000 : 32'h40A00000);
      push_exp(1'b1, id, c + 27 + 28 * k,
               id ? 32'h7F800000 : 32'h40000000,
               id ? 32'h3F800000 : 32'h41200000,
               id ? 32'h00000000 : 32'h40A00000);
    end
    repeat (85) @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (30) @(negedge clk);
    check_output("fair_final_result", result, 32'h7F800000);
    check_output("fair_idle", {31'd0, busy}, 32'd0);

    check_output("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
